// File: rtl/linebuf.sv
// linebuf: double-buffered scanline store. One bank captures fetcher words while the other
// bank is serialized MSB-first to a 1-bit pixel stream under hden_i. Banks swap on HSYNC rise.
module linebuf #(
    parameter int unsigned DEPTH_LOG2 = 9
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic        hden_i,
    input  logic        s_we_i,
    input  logic [15:0] s_dat_i,
    output logic        pixel_o,
    output logic        overflow_o,
    output logic        underrun_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {StIdle, StPrime, StRun} state_t;

    logic [15:0]         mem [2*DEPTH];
    logic                wbank;
    logic [PW-1:0]       wptr;
    logic [PW-1:0]       wcnt [2];
    logic [PW-1:0]       rptr;
    logic [3:0]          bcnt;
    // Low 15 bits only: the word MSB goes straight to pixel_o on load.
    logic [14:0]         shreg;
    logic [15:0]         hold;
    logic [15:0]         rd_data;
    logic                rd_vld;
    logic                pstep;
    logic                cur_ok;
    logic                hs_q;
    state_t              state;

    logic                hs_rise;
    logic                full;
    logic                wr_en;
    logic [DEPTH_LOG2:0] wr_addr;
    logic                rd_en;
    logic [DEPTH_LOG2:0] rd_addr;
    logic [PW-1:0]       widx;
    logic                word_ok;
    logic                load;

    // Edge detect, write/read addressing and the underrun test for the word being loaded.
    always_comb begin
        hs_rise = hsync_i & ~hs_q;
        full    = (wptr == PW'(DEPTH));
        // The edge-cycle write always fits: it lands at word 0 of the fresh bank.
        wr_en   = s_we_i & (hs_rise | ~full);
        wr_addr = hs_rise ? {~wbank, {DEPTH_LOG2{1'b0}}} : {wbank, wptr[DEPTH_LOG2-1:0]};
        load    = (state == StRun) & hden_i & (bcnt == 4'd0);
        rd_en   = ((state == StPrime) & ~pstep) | load;
        rd_addr = {~wbank, (state == StPrime) ? {DEPTH_LOG2{1'b0}} : rptr[DEPTH_LOG2-1:0]};
        // rptr already points one past the word sitting in hold.
        widx    = rptr - PW'(1);
        word_ok = (widx < wcnt[~wbank]);
    end

    // Bank RAM: one write port, one synchronous read port.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_addr] <= s_dat_i;
        if (rd_en) rd_data <= mem[rd_addr];
    end

    // Write pointer, bank swap, read FSM, serializer and sticky status.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wbank      <= 1'b0;
            wptr       <= '0;
            wcnt[0]    <= '0;
            wcnt[1]    <= '0;
            rptr       <= '0;
            bcnt       <= '0;
            shreg      <= '0;
            hold       <= '0;
            rd_vld     <= 1'b0;
            pstep      <= 1'b0;
            cur_ok     <= 1'b0;
            hs_q       <= 1'b0;
            state      <= StIdle;
            pixel_o    <= 1'b0;
            overflow_o <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            hs_q    <= hsync_i;
            pixel_o <= 1'b0;
            rd_vld  <= load & ~hs_rise & ~vsync_i;

            if (hs_rise) begin
                wcnt[wbank] <= wptr;
                wbank       <= ~wbank;
                wptr        <= s_we_i ? PW'(1) : '0;
            end else if (s_we_i) begin
                if (full) overflow_o <= 1'b1;
                else      wptr       <= wptr + PW'(1);
            end

            // Refill lands one cycle after the read issued at bcnt=0.
            if (rd_vld && state == StRun) hold <= rd_data;

            if (hs_rise) begin
                rptr  <= '0;
                bcnt  <= '0;
                pstep <= 1'b0;
                state <= StPrime;
            end else begin
                case (state)
                    StPrime: begin
                        if (!pstep) begin
                            pstep <= 1'b1;
                        end else begin
                            hold  <= rd_data;
                            rptr  <= PW'(1);
                            state <= StRun;
                        end
                    end
                    StRun: begin
                        if (hden_i) begin
                            bcnt <= bcnt + 4'd1;
                            if (bcnt == 4'd0) begin
                                shreg   <= hold[14:0];
                                cur_ok  <= word_ok;
                                pixel_o <= hold[15] & word_ok;
                                if (!word_ok) underrun_o <= 1'b1;
                                // Saturate so a long line never wraps back into valid words.
                                if (rptr != {PW{1'b1}}) rptr <= rptr + PW'(1);
                            end else begin
                                shreg   <= {shreg[13:0], 1'b0};
                                pixel_o <= shreg[14] & cur_ok;
                                if (!cur_ok) underrun_o <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end

            if (vsync_i) begin
                state      <= StIdle;
                pixel_o    <= 1'b0;
                overflow_o <= 1'b0;
                underrun_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_linebuf.sv
// tb_linebuf: drives two linebuf instances (512-word and 4-word banks) with the same stimulus
// and scores every cycle's outputs against a behavioural line model.
module tb_linebuf;

    logic        clk = 1'b0;
    logic        reset, hsync, vsync, hden, s_we;
    logic [15:0] s_dat;
    logic        pix0, ovf0, und0;
    logic        pix1, ovf1, und1;

    always #5 clk = ~clk;

    linebuf #(.DEPTH_LOG2(9)) dut0 (
        .clk_i(clk), .reset_i(reset), .hsync_i(hsync), .vsync_i(vsync), .hden_i(hden),
        .s_we_i(s_we), .s_dat_i(s_dat), .pixel_o(pix0), .overflow_o(ovf0), .underrun_o(und0)
    );

    linebuf #(.DEPTH_LOG2(2)) dut1 (
        .clk_i(clk), .reset_i(reset), .hsync_i(hsync), .vsync_i(vsync), .hden_i(hden),
        .s_we_i(s_we), .s_dat_i(s_dat), .pixel_o(pix1), .overflow_o(ovf1), .underrun_o(und1)
    );

    typedef struct packed {
        logic p0, p1, o0, o1, u0, u1;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] cap0[$], shown0[$], cap1[$], shown1[$];
    logic        m_hs, m_run, e_o0, e_o1, e_u0, e_u1;
    int          m_since, m_n, cyc;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Model pixel for one bank depth given the displayed line.
    task automatic model_pix(input logic [15:0] line[$], output logic p, inout logic u);
        int          w;
        logic [15:0] word;
        w = m_n / 16;
        p = 1'b0;
        if (w < line.size()) begin
            word = line[w];
            p = word[15 - (m_n % 16)];
        end else begin
            u = 1'b1;
        end
    endtask

    task automatic step(input logic rst, input logic hs, input logic vs, input logic de,
                        input logic we, input logic [15:0] dat);
        exp_t e;
        exp_t got;
        logic edge_c;
        int   since_c;
        reset = rst; hsync = hs; vsync = vs; hden = de; s_we = we; s_dat = dat;
        e = '0;
        if (rst) begin
            cap0.delete(); shown0.delete(); cap1.delete(); shown1.delete();
            m_hs = 0; m_run = 0; m_since = 0; m_n = 0;
            e_o0 = 0; e_o1 = 0; e_u0 = 0; e_u1 = 0;
        end else begin
            edge_c  = hs && !m_hs;
            m_hs    = hs;
            since_c = (m_since < 1000) ? m_since + 1 : m_since;
            if (!vs && !edge_c && m_run && since_c >= 3 && de) begin
                model_pix(shown0, e.p0, e_u0);
                model_pix(shown1, e.p1, e_u1);
                m_n++;
            end
            if (edge_c) begin
                shown0 = cap0; cap0.delete();
                shown1 = cap1; cap1.delete();
                m_n = 0; m_since = 0; m_run = 1;
            end else begin
                m_since = since_c;
            end
            if (we) begin
                if (cap0.size() < 512) cap0.push_back(dat); else e_o0 = 1;
                if (cap1.size() < 4)   cap1.push_back(dat); else e_o1 = 1;
            end
            if (vs) begin
                m_run = 0; e_o0 = 0; e_o1 = 0; e_u0 = 0; e_u1 = 0;
            end
        end
        e.o0 = e_o0; e.o1 = e_o1; e.u0 = e_u0; e.u1 = e_u1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e = exp_q.pop_front();
        got = '{p0: pix0, p1: pix1, o0: ovf0, o1: ovf1, u0: und0, u1: und1};
        check_val("pixel0", 32'(got.p0), 32'(e.p0));
        check_val("pixel1", 32'(got.p1), 32'(e.p1));
        check_val("overflow0", 32'(got.o0), 32'(e.o0));
        check_val("overflow1", 32'(got.o1), 32'(e.o1));
        check_val("underrun0", 32'(got.u0), 32'(e.u0));
        check_val("underrun1", 32'(got.u1), 32'(e.u1));
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 16'h0);
    endtask

    task automatic wr(input logic [15:0] d);
        step(0, 0, 0, 0, 1, d);
    endtask

    // Edge cycle, then one cycle low: hden may start on the step after this returns + 1 idle.
    task automatic hpulse();
        step(0, 1, 0, 0, 0, 16'h0);
        step(0, 0, 0, 0, 0, 16'h0);
    endtask

    task automatic show(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 1, 0, 16'h0);
    endtask

    initial begin
        cyc = 0;
        step(1, 0, 0, 0, 0, 16'h0);
        step(1, 0, 0, 0, 0, 16'h0);
        idle(2);

        // Basic line: 1010010111110000 then 0000000000000001.
        wr(16'hA5F0);
        wr(16'h0001);
        hpulse();
        idle(1);
        show(32);
        check_val("basic_no_underrun", 32'(und0), 32'd0);
        idle(3);

        // Ping-pong: line A of ones displays while line B of zeros is captured.
        wr(16'hFFFF);
        hpulse();
        idle(1);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 1, (i == 0), 16'h0000);
        hpulse();
        idle(1);
        show(16);
        idle(2);

        // Underrun: one word, 20 pixels; vsync clears the flag.
        wr(16'h8000);
        hpulse();
        idle(1);
        show(20);
        check_val("underrun_set", 32'(und0), 32'd1);
        step(0, 0, 1, 0, 0, 16'h0);
        check_val("underrun_clr", 32'(und0), 32'd0);
        idle(2);

        // Overflow on the 4-word instance: fifth write dropped, wcnt stays 4.
        wr(16'h8001); wr(16'h4002); wr(16'h2004); wr(16'h1008); wr(16'hF00F);
        check_val("ovf_small", 32'(ovf1), 32'd1);
        check_val("ovf_big", 32'(ovf0), 32'd0);
        hpulse();
        idle(1);
        show(64);
        check_val("ovf_wcnt4_ok", 32'(und1), 32'd0);
        show(16);
        check_val("ovf_wcnt4_under", 32'(und1), 32'd1);
        check_val("big_no_under", 32'(und0), 32'd0);
        step(0, 0, 1, 0, 0, 16'h0);
        idle(2);

        // Edge-cycle write lands at word 0 of the new bank.
        step(0, 1, 0, 0, 1, 16'h1234);
        step(0, 0, 0, 0, 1, 16'h00FF);
        idle(2);
        hpulse();
        idle(1);
        show(32);
        idle(2);

        // Long hsync gives one swap; early hden is blank; gappy hden holds position.
        wr(16'hC3C3);
        wr(16'h5A5A);
        for (int i = 0; i < 4; i++) step(0, 1, 0, (i > 0), 0, 16'h0);
        step(0, 0, 0, 1, 0, 16'h0);
        for (int i = 0; i < 60; i++) step(0, 0, 0, 1'($urandom_range(0, 1)), 0, 16'h0);
        idle(2);

        // Edge during RUN truncates; reset mid-line discards and the next line underruns.
        wr(16'hFFFF);
        wr(16'hAAAA);
        hpulse();
        idle(1);
        show(8);
        hpulse();
        idle(1);
        show(8);
        step(1, 0, 0, 1, 0, 16'h0);
        check_val("rst_pixel", 32'(pix0), 32'd0);
        check_val("rst_under", 32'(und0), 32'd0);
        hpulse();
        idle(1);
        show(16);
        check_val("rst_then_under", 32'(und0), 32'd1);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/linebuf.md
# linebuf

Double-buffered scanline store sitting between the CGIA fetcher and the video output. It receives framebuffer words from the fetcher's write strobe during one scanline. During the next scanline it serializes the previously captured line into a 1-bit-per-pixel stream, timed by the CRTC's horizontal display-enable. Banks swap on every HSYNC rising edge, so fetch and display of adjacent lines overlap.

## Interface
Parameters:
- DEPTH_LOG2, default 9: log2 of the word capacity of each bank (512 words of 16 bits).

Ports:
- clk_i  in  1  SYSCON clock; the only clock.
- reset_i  in  1  SYSCON reset; synchronous, active-high.
- hsync_i  in  1  CRTC HSYNC, active high; its rising edge swaps banks.
- vsync_i  in  1  CRTC VSYNC, active high; blanks output and clears status.
- hden_i  in  1  CRTC horizontal display enable; each high cycle consumes one pixel.
- s_we_i  in  1  Word write strobe from the fetcher; data is valid this cycle.
- s_dat_i  in  16  Word written when s_we_i=1.
- pixel_o  out  1  Serialized pixel, registered.
- overflow_o  out  1  Sticky: a write was dropped because the write bank was full.
- underrun_o  out  1  Sticky: display consumed past the words captured for the line.

## Operation
- State:
  - wbank: selects the write bank; the read bank is ~wbank.
  - wptr: DEPTH_LOG2+1 bits.
  - wcnt[2]: captured word count per bank, DEPTH_LOG2+1 bits each.
  - rptr: read word index.
  - bcnt: 4-bit bit counter.
  - 16-bit shift register and 16-bit next-word holding register.
  - hs_q: registered hsync_i.
  - Read FSM with states IDLE, PRIME, RUN.
- Edge detect: an edge is hsync_i=1 and hs_q=0. On an edge:
  - wcnt[wbank] is set to wptr, then wbank toggles.
  - wptr is set to 0, rptr to 0, bcnt to 0, and the FSM goes to PRIME.
- Write port: when s_we_i=1 and wptr < 2^DEPTH_LOG2, mem[wbank][wptr] is written with s_dat_i and wptr increments. When wptr = 2^DEPTH_LOG2, the write is dropped and overflow_o is set.
- Write on the edge cycle: the write lands in the new write bank at word 0, and wptr becomes 1.
- PRIME: fetch word 0 of the read bank into the holding register. Synchronous RAM read, so this takes 2 cycles. Then rptr=1, and the FSM goes to RUN.
- RUN, on each hden_i=1 cycle:
  - When bcnt=0, the shift register loads from the holding register, the read of word rptr is issued into the holding register, and rptr increments.
  - Otherwise the shift register shifts left.
  - pixel_o is registered from the shift register MSB (the MSB of the loaded word when bcnt=0).
  - bcnt increments, modulo 16.
- Bit order: pixel n of a line (counting hden_i=1 cycles from 0) is bit 15-(n mod 16) of word floor(n/16). MSB first.
- Underrun: if the word index floor(n/16) is ≥ wcnt[read bank], pixel_o=0 for that pixel and underrun_o is set.
- Blanking: pixel_o=0 in any cycle following:
  - hden_i=0;
  - vsync_i=1;
  - the FSM being in IDLE or PRIME.
- vsync_i=1 clears overflow_o and underrun_o, and forces the FSM to IDLE. The write port keeps operating and edge detection continues.
- After reset, wcnt is 0 for both banks, so the first displayed line underruns. This is allowed and is flagged.

## Timing
- Reset values:
  - pixel_o=0, overflow_o=0, underrun_o=0.
  - wbank=0, wptr=0, rptr=0, bcnt=0.
  - wcnt[0]=wcnt[1]=0.
  - hs_q=0, FSM=IDLE.
  - Memory contents are undefined.
- Reset asserted mid-line: all of the above take effect on the next clock, and any in-flight line is discarded.
- Edge-to-ready: hden_i may first assert no earlier than 3 cycles after the edge cycle. An earlier assertion yields blank pixels; it does not corrupt data.
- Pixel latency: pixel_o reflects the hden_i cycle of the previous clock (1-cycle latency).
- Word refill: there is always 16 cycles of slack, so continuous hden_i never stalls.
- hden_i gaps: a low hden_i holds bcnt, rptr and the shift register, so a line may be split by gaps.
- An edge during RUN truncates the current line immediately.
- hsync_i held high for multiple cycles produces exactly one swap.

## Test plan
- Basic line:
  - Stimulus: write 0xA5F0, 0x0001 via s_we_i; pulse hsync_i; after 3 cycles hold hden_i=1 for 32 cycles.
  - Response: pixel_o stream (1-cycle delayed) is 1010010111110000 then 0000000000000001; no flags set.
- Ping-pong:
  - Stimulus: capture line A (0xFFFF); pulse hsync; write line B (0x0000) while A displays; pulse hsync; display.
  - Response: 16 ones, then 16 zeros.
- Underrun:
  - Stimulus: capture 1 word (0x8000), swap, display 20 pixels.
  - Response: 1 then 15 zeros; pixels 16-19 are 0; underrun_o=1. Pulsing vsync_i then clears underrun_o.
- Overflow, with DEPTH_LOG2=2:
  - Stimulus: write 5 words.
  - Response: the 5th write is dropped, overflow_o=1, wcnt=4 after the swap.
- Edge-cycle write:
  - Stimulus: assert s_we_i with 0x1234 on the hsync rising-edge cycle, then pulse hsync again and display.
  - Response: word 0 of that line shows 0x1234.
- Reset mid-line:
  - Stimulus: assert reset_i during RUN.
  - Response: the next cycle shows pixel_o=0 and flags 0; the following display underruns because wcnt=0.
